// File: rtl/mbldcm_startup_sequencer_if.sv
// Control and status bundle between the startup sequencer and its supervisor.
// The supervisor drives the requests and configuration; the sequencer drives the motor-core controls.
interface mbldcm_startup_sequencer_if #(
  parameter int unsigned pDutyWidth = 33
);
  logic                  iStart;
  logic                  iStopReq;
  logic                  iAbort;
  logic [31:0]           iStartDiv;
  logic [31:0]           iTargetDiv;
  logic [31:0]           iDivStep;
  logic [pDutyWidth-1:0] iAlignDuty;
  logic [pDutyWidth-1:0] iRunDuty;
  logic [15:0]           iStepInterval;

  logic                  oEnable;
  logic                  oStop;
  logic [31:0]           oDiv;
  logic [pDutyWidth-1:0] oDuty;
  logic [2:0]            oPhaseUpdate;
  logic                  oLatchPhaseUpdate;
  logic [2:0]            oState;
  logic                  oAtSpeed;

  modport master (
    output iStart, iStopReq, iAbort, iStartDiv, iTargetDiv, iDivStep,
    output iAlignDuty, iRunDuty, iStepInterval,
    input  oEnable, oStop, oDiv, oDuty, oPhaseUpdate, oLatchPhaseUpdate, oState, oAtSpeed
  );

  modport slave (
    input  iStart, iStopReq, iAbort, iStartDiv, iTargetDiv, iDivStep,
    input  iAlignDuty, iRunDuty, iStepInterval,
    output oEnable, oStop, oDiv, oDuty, oPhaseUpdate, oLatchPhaseUpdate, oState, oAtSpeed
  );
endinterface

// File: rtl/mbldcm_startup_sequencer.sv
// Brushless motor startup sequencer: rotor alignment, divider ramp to target speed, run, and a
// controlled coast-down of the duty. All outputs are registered.
module mbldcm_startup_sequencer #(
  parameter int unsigned pDutyWidth   = 33,
  parameter int unsigned pAlignCycles = 32'd100000
) (
  input logic                        iClock,
  input logic                        iReset,
  mbldcm_startup_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAlign = 3'd1,
    StRamp  = 3'd2,
    StRun   = 3'd3,
    StCoast = 3'd4
  } state_e;

  localparam logic [31:0] AlignLast = (pAlignCycles == 0) ? 32'd0 : 32'(pAlignCycles - 1);
  localparam logic [pDutyWidth-1:0] DutyOne = pDutyWidth'(1);

  state_e                stateQ, stateD;
  logic                  enableQ, enableD;
  logic                  stopQ, stopD;
  logic [31:0]           divQ, divD;
  logic [pDutyWidth-1:0] dutyQ, dutyD;
  logic [2:0]            phaseQ, phaseD;
  logic                  latchQ, latchD;
  logic                  atSpeedQ, atSpeedD;
  logic [15:0]           timerQ, timerD;
  logic [31:0]           alignCntQ, alignCntD;

  logic [31:0]           shStartDivQ, shStartDivD;
  logic [31:0]           shTargetDivQ, shTargetDivD;
  logic [31:0]           shDivStepQ, shDivStepD;
  logic [pDutyWidth-1:0] shAlignDutyQ, shAlignDutyD;
  logic [pDutyWidth-1:0] shRunDutyQ, shRunDutyD;
  logic [15:0]           shIntervalQ, shIntervalD;

  logic [15:0] interval;
  logic [31:0] step;
  logic [31:0] rampGap;
  logic        timerDone;

  // Zero interval or step would stall the sequence, so both are treated as 1.
  assign interval  = (shIntervalQ == 16'd0) ? 16'd1 : shIntervalQ;
  assign step      = (shDivStepQ == 32'd0) ? 32'd1 : shDivStepQ;
  assign timerDone = (timerQ >= (interval - 16'd1));
  assign rampGap   = divQ - shTargetDivQ;

  always_comb begin
    stateD       = stateQ;
    enableD      = enableQ;
    stopD        = stopQ;
    divD         = divQ;
    dutyD        = dutyQ;
    phaseD       = phaseQ;
    latchD       = 1'b0;
    atSpeedD     = atSpeedQ;
    timerD       = timerQ;
    alignCntD    = alignCntQ;
    shStartDivD  = shStartDivQ;
    shTargetDivD = shTargetDivQ;
    shDivStepD   = shDivStepQ;
    shAlignDutyD = shAlignDutyQ;
    shRunDutyD   = shRunDutyQ;
    shIntervalD  = shIntervalQ;

    if (bus.iAbort) begin
      stateD   = StIdle;
      enableD  = 1'b0;
      stopD    = 1'b1;
      dutyD    = '0;
      atSpeedD = 1'b0;
    end else if (bus.iStopReq && (stateQ inside {StAlign, StRamp, StRun})) begin
      stateD   = StCoast;
      stopD    = 1'b0;
      atSpeedD = 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (bus.iStart) begin
            shStartDivD  = bus.iStartDiv;
            shTargetDivD = bus.iTargetDiv;
            shDivStepD   = bus.iDivStep;
            shAlignDutyD = bus.iAlignDuty;
            shRunDutyD   = bus.iRunDuty;
            shIntervalD  = bus.iStepInterval;
            stateD       = StAlign;
            enableD      = 1'b1;
            stopD        = 1'b1;
            dutyD        = bus.iAlignDuty;
            phaseD       = 3'd0;
            latchD       = 1'b1;
          end
        end
        StAlign: begin
          dutyD = shAlignDutyQ;
          if (alignCntQ >= AlignLast) begin
            stateD = StRamp;
            stopD  = 1'b0;
            dutyD  = shRunDutyQ;
            divD   = (shStartDivQ > shTargetDivQ) ? shStartDivQ : shTargetDivQ;
          end else begin
            alignCntD = alignCntQ + 32'd1;
          end
        end
        StRamp: begin
          if (divQ == shTargetDivQ) begin
            stateD   = StRun;
            atSpeedD = 1'b1;
          end else if (timerDone) begin
            // Saturate at the target instead of stepping past it.
            divD   = (rampGap <= step) ? shTargetDivQ : (divQ - step);
            timerD = '0;
          end else begin
            timerD = timerQ + 16'd1;
          end
        end
        StRun: begin
          atSpeedD = 1'b1;
        end
        StCoast: begin
          if (dutyQ == '0) begin
            stateD  = StIdle;
            enableD = 1'b0;
            stopD   = 1'b1;
          end else if (timerDone) begin
            dutyD  = dutyQ - DutyOne;
            timerD = '0;
          end else begin
            timerD = timerQ + 16'd1;
          end
        end
        default: begin
          stateD  = StIdle;
          enableD = 1'b0;
          stopD   = 1'b1;
          dutyD   = '0;
        end
      endcase
    end

    if (stateD != stateQ) begin
      timerD    = '0;
      alignCntD = '0;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      stateQ       <= StIdle;
      enableQ      <= 1'b0;
      stopQ        <= 1'b1;
      divQ         <= '0;
      dutyQ        <= '0;
      phaseQ       <= '0;
      latchQ       <= 1'b0;
      atSpeedQ     <= 1'b0;
      timerQ       <= '0;
      alignCntQ    <= '0;
      shStartDivQ  <= '0;
      shTargetDivQ <= '0;
      shDivStepQ   <= '0;
      shAlignDutyQ <= '0;
      shRunDutyQ   <= '0;
      shIntervalQ  <= '0;
    end else begin
      stateQ       <= stateD;
      enableQ      <= enableD;
      stopQ        <= stopD;
      divQ         <= divD;
      dutyQ        <= dutyD;
      phaseQ       <= phaseD;
      latchQ       <= latchD;
      atSpeedQ     <= atSpeedD;
      timerQ       <= timerD;
      alignCntQ    <= alignCntD;
      shStartDivQ  <= shStartDivD;
      shTargetDivQ <= shTargetDivD;
      shDivStepQ   <= shDivStepD;
      shAlignDutyQ <= shAlignDutyD;
      shRunDutyQ   <= shRunDutyD;
      shIntervalQ  <= shIntervalD;
    end
  end

  assign bus.oState            = stateQ;
  assign bus.oEnable           = enableQ;
  assign bus.oStop             = stopQ;
  assign bus.oDiv              = divQ;
  assign bus.oDuty             = dutyQ;
  assign bus.oPhaseUpdate      = phaseQ;
  assign bus.oLatchPhaseUpdate = latchQ;
  assign bus.oAtSpeed          = atSpeedQ;

endmodule

// File: tb/tb_mbldcm_startup_sequencer.sv
// Scoreboard bench for the startup sequencer: each scenario is expanded into an expected
// per-cycle output trace from the sequencing rules, and a monitor compares every cycle.
module tb_mbldcm_startup_sequencer;
  localparam int unsigned DW          = 33;
  localparam int unsigned AlignCycles = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mbldcm_startup_sequencer_if #(.pDutyWidth(DW)) bus ();

  mbldcm_startup_sequencer #(
    .pDutyWidth   (DW),
    .pAlignCycles (AlignCycles)
  ) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [2:0]  state;
    logic        en;
    logic        stop;
    logic [31:0] div;
    logic [32:0] duty;
    logic        latch;
    logic [2:0]  phase;
    logic        atSpeed;
  } snap_t;

  typedef struct {
    longint startDiv, targetDiv, step, interval, align, run;
  } cfg_t;

  snap_t  sbq[$];
  snap_t  nom[$];
  snap_t  seq[$];
  int     checks  = 0;
  int     errors  = 0;
  longint lastDiv = 0;

  function automatic snap_t mk(int st, bit en, bit sp, longint div, longint duty, bit la, bit at);
    snap_t s;
    s.state   = 3'(st);
    s.en      = en;
    s.stop    = sp;
    s.div     = 32'(div);
    s.duty    = 33'(duty);
    s.latch   = la;
    s.phase   = 3'd0;
    s.atSpeed = at;
    return s;
  endfunction

  function automatic cfg_t noiseCfg();
    cfg_t c;
    c.startDiv  = $urandom;
    c.targetDiv = $urandom;
    c.step      = $urandom;
    c.interval  = $urandom_range(0, 65535);
    c.align     = $urandom;
    c.run       = $urandom;
    return c;
  endfunction

  function automatic cfg_t randCfg();
    cfg_t c;
    c.startDiv  = $urandom_range(0, 200);
    c.targetDiv = $urandom_range(0, 200);
    c.step      = $urandom_range(0, 40);
    c.interval  = $urandom_range(0, 3);
    c.align     = $urandom_range(0, 6);
    c.run       = $urandom_range(0, 6);
    return c;
  endfunction

  function automatic cfg_t mkCfg(longint s, longint t, longint st, longint iv, longint a,
                                 longint r);
    cfg_t c;
    c.startDiv = s; c.targetDiv = t; c.step = st; c.interval = iv; c.align = a; c.run = r;
    return c;
  endfunction

  task automatic drive(bit r, bit s, bit sp, bit ab, cfg_t c, snap_t e);
    @(negedge clk);
    rst               = r;
    bus.iStart        = s;
    bus.iStopReq      = sp;
    bus.iAbort        = ab;
    bus.iStartDiv     = 32'(c.startDiv);
    bus.iTargetDiv    = 32'(c.targetDiv);
    bus.iDivStep      = 32'(c.step);
    bus.iStepInterval = 16'(c.interval);
    bus.iAlignDuty    = 33'(c.align);
    bus.iRunDuty      = 33'(c.run);
    sbq.push_back(e);
    @(posedge clk);
  endtask

  // kind: 0 = stop request, 1 = abort, 2 = reset, asserted while trace cycle k is showing.
  task automatic runScenario(cfg_t c, int kind, int k, int runCycles);
    longint iv, st, d;
    snap_t  last, idle;
    cfg_t   nz;
    bit     r, s, sp, ab;
    iv = (c.interval == 0) ? 1 : c.interval;
    st = (c.step == 0) ? 1 : c.step;
    nom.delete();
    seq.delete();
    for (int i = 0; i < int'(AlignCycles); i++) nom.push_back(mk(1, 1, 1, lastDiv, c.align, i == 0, 0));
    d = (c.startDiv > c.targetDiv) ? c.startDiv : c.targetDiv;
    while (d != c.targetDiv) begin
      for (longint j = 0; j < iv; j++) nom.push_back(mk(2, 1, 0, d, c.run, 0, 0));
      d = (d - st < c.targetDiv) ? c.targetDiv : d - st;
    end
    nom.push_back(mk(2, 1, 0, c.targetDiv, c.run, 0, 0));
    for (int i = 0; i < runCycles; i++) nom.push_back(mk(3, 1, 0, c.targetDiv, c.run, 0, 1));
    if (k >= nom.size()) k = nom.size() - 1;
    for (int i = 0; i <= k; i++) seq.push_back(nom[i]);
    last = nom[k];
    if (kind == 0) begin
      for (longint v = longint'(last.duty); v > 0; v--)
        for (longint j = 0; j < iv; j++) seq.push_back(mk(4, 1, 0, last.div, v, 0, 0));
      seq.push_back(mk(4, 1, 0, last.div, 0, 0, 0));
      idle = mk(0, 0, 1, last.div, 0, 0, 0);
    end else if (kind == 1) begin
      idle = mk(0, 0, 1, last.div, 0, 0, 0);
    end else begin
      idle = mk(0, 0, 1, 0, 0, 0, 0);
    end
    repeat (3) seq.push_back(idle);
    lastDiv = longint'(idle.div);

    drive(0, 1, 0, 0, c, seq[0]);
    for (int e = 1; e < seq.size(); e++) begin
      nz = noiseCfg();
      r = 0; s = 0; sp = 0; ab = 0;
      if (e == k + 1) begin
        s = 1'($urandom % 2);
        if (kind == 0) sp = 1;
        else if (kind == 1) begin ab = 1; sp = 1'($urandom % 2); end
        else begin r = 1; sp = 1'($urandom % 2); ab = 1'($urandom % 2); end
      end else if (seq[e-1].state == 3'd4) begin
        s  = 1'($urandom % 2);
        sp = 1'($urandom % 2);
      end else if (seq[e-1].state == 3'd0) begin
        sp = 1'($urandom % 2);
        if ($urandom % 2 == 1) begin s = 1; ab = 1; end
      end else begin
        s = 1'($urandom % 2);
      end
      drive(r, s, sp, ab, nz, seq[e]);
    end
  endtask

  always @(posedge clk) begin
    snap_t exp, act;
    #1;
    if (sbq.size() > 0) begin
      exp = sbq.pop_front();
      act.state   = bus.oState;
      act.en      = bus.oEnable;
      act.stop    = bus.oStop;
      act.div     = bus.oDiv;
      act.duty    = bus.oDuty;
      act.latch   = bus.oLatchPhaseUpdate;
      act.phase   = bus.oPhaseUpdate;
      act.atSpeed = bus.oAtSpeed;
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle t=%0t got st=%0d en=%0b stop=%0b div=%0d duty=%0d latch=%0b ph=%0d at=%0b required st=%0d en=%0b stop=%0b div=%0d duty=%0d latch=%0b ph=%0d at=%0b",
                 $time, act.state, act.en, act.stop, act.div, act.duty, act.latch, act.phase,
                 act.atSpeed, exp.state, exp.en, exp.stop, exp.div, exp.duty, exp.latch,
                 exp.phase, exp.atSpeed);
      end
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.iStart = 0; bus.iStopReq = 0; bus.iAbort = 0;
    bus.iStartDiv = 0; bus.iTargetDiv = 0; bus.iDivStep = 0; bus.iStepInterval = 0;
    bus.iAlignDuty = 0; bus.iRunDuty = 0;

    // Reset dominates a simultaneous start request.
    repeat (3) drive(1, 1, 0, 0, noiseCfg(), mk(0, 0, 1, 0, 0, 0, 0));

    runScenario(mkCfg(100, 70, 10, 2, 5, 20), 0, 1000, 3);
    runScenario(mkCfg(100, 70, 40, 2, 5, 20), 0, 1000, 3);
    runScenario(mkCfg(100, 70, 10, 1, 5, 3), 0, 1000, 2);
    runScenario(mkCfg(100, 70, 10, 2, 5, 20), 1, 6, 2);
    runScenario(mkCfg(100, 70, 10, 2, 5, 20), 2, 2, 2);
    runScenario(mkCfg(50, 80, 10, 2, 5, 20), 0, 1000, 2);

    for (int n = 0; n < 30; n++) begin
      r = int'($urandom % 4);
      runScenario(randCfg(), (r < 2) ? 0 : r - 1, int'($urandom_range(0, 30)),
                  int'($urandom_range(1, 4)));
    end

    @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
